// File: rtl/pll_seq_pkg.sv
// Shared definitions for the PLL reset sequencer: the sequencer state
// encoding, default timing constants and the per-state counter reload value.
package pll_seq_pkg;

   typedef enum logic [2:0] {
      PLL_RST   = 3'd0,
      WAIT_LOCK = 3'd1,
      STABLE    = 3'd2,
      HOLD      = 3'd3,
      RUN       = 3'd4,
      FAULT     = 3'd5
   } seqState_e;

   localparam int DEF_SYNC_STAGES        = 2;
   localparam int DEF_PLL_RST_CYCLES     = 16;
   localparam int DEF_LOCK_TIMEOUT       = 50000;
   localparam int DEF_LOCK_STABLE_CYCLES = 1024;
   localparam int DEF_CORE_RST_HOLD      = 64;
   localparam int DEF_MAX_RETRY          = 8;
   localparam int DEF_CNT_W              = 16;

   // The sequencer uses a single down-counter that is reloaded whenever a
   // state is entered. A state lasting N cycles reloads N-1 and leaves when
   // the counter reads zero. RUN and FAULT are not timed, so they load zero.
   function automatic int reloadValue(
      input seqState_e st,
      input int        pllRstCycles,
      input int        lockTimeout,
      input int        stableCycles,
      input int        holdCycles
   );
      int value;
      value = 0;
      case (st)
         PLL_RST:   value = pllRstCycles - 1;
         WAIT_LOCK: value = lockTimeout - 1;
         STABLE:    value = stableCycles - 1;
         HOLD:      value = holdCycles - 1;
         default:   value = 0;
      endcase
      return value;
   endfunction

endpackage

// File: rtl/cdc_sync_bit.sv
// Single-bit synchronizer: a chain of STAGES flops that brings an
// asynchronous level into the clk domain.
//   clk   - destination clock
//   rst_n - asynchronous active-low reset, clears every stage
//   d     - asynchronous input level
//   q     - synchronized level, STAGES clk edges behind d
module cdc_sync_bit #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic [STAGES-1:0] syncQ;

   // Shift the input through the flop chain; only the last stage is used
   // downstream so metastability in the first stage has a full cycle to settle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         syncQ <= '0;
      end else begin
         syncQ <= {syncQ[STAGES-2:0], d};
      end
   end

   assign q = syncQ[STAGES-1];

endmodule

// File: rtl/pll_rst_seq.sv
// PLL reset sequencer. Runs on the free-running board clock, pulses the PLL
// reset, waits for a lock that stays put, then releases the CPU-domain reset.
// A PLL that does not lock in time is retried; too many failures park the
// sequencer in FAULT. A lock loss after the stable check re-asserts the
// system reset and restarts the whole sequence.
//   clk          - free-running board clock
//   rst_n        - asynchronous active-low reset
//   pll_lock_i   - PLL lock, asynchronous to clk
//   pll_rst_o    - PLL reset request, active high
//   sys_rst_n_o  - CPU-domain reset, active low
//   locked_o     - high only while running
//   lock_lost_o  - one-cycle pulse for each lock loss in HOLD or RUN
//   fault_o      - sticky, retries exhausted
//   retry_cnt_o  - failed lock attempts since the last RUN entry
//   loss_cnt_o   - saturating count of lock-loss events
module pll_rst_seq
   import pll_seq_pkg::*;
#(
   parameter int SYNC_STAGES        = DEF_SYNC_STAGES,
   parameter int PLL_RST_CYCLES     = DEF_PLL_RST_CYCLES,
   parameter int LOCK_TIMEOUT       = DEF_LOCK_TIMEOUT,
   parameter int LOCK_STABLE_CYCLES = DEF_LOCK_STABLE_CYCLES,
   parameter int CORE_RST_HOLD      = DEF_CORE_RST_HOLD,
   parameter int MAX_RETRY          = DEF_MAX_RETRY,
   parameter int CNT_W              = DEF_CNT_W
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       pll_lock_i,
   output logic       pll_rst_o,
   output logic       sys_rst_n_o,
   output logic       locked_o,
   output logic       lock_lost_o,
   output logic       fault_o,
   output logic [7:0] retry_cnt_o,
   output logic [7:0] loss_cnt_o
);

   localparam logic [CNT_W-1:0] RESET_CNT = CNT_W'(reloadValue(PLL_RST,
      PLL_RST_CYCLES, LOCK_TIMEOUT, LOCK_STABLE_CYCLES, CORE_RST_HOLD));
   localparam logic [7:0] RETRY_LIMIT = 8'(MAX_RETRY);

   seqState_e        stateQ, stateD;
   logic [CNT_W-1:0] cntQ, cntD;
   logic             pllRstQ, pllRstD;
   logic             sysRstNQ, sysRstND;
   logic             lockedQ, lockedD;
   logic             lockLostQ, lockLostD;
   logic             faultQ, faultD;
   logic [7:0]       retryQ, retryD;
   logic [7:0]       lossQ, lossD;
   logic [7:0]       retryInc;
   logic             lossEvent;
   logic             cntZero;
   logic             lockS;

   // Every decision is taken on the synchronized lock, never on the raw pin.
   cdc_sync_bit #(
      .STAGES (SYNC_STAGES)
   ) uLockSync (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (pll_lock_i),
      .q     (lockS)
   );

   function automatic logic [CNT_W-1:0] reloadFor(input seqState_e st);
      return CNT_W'(reloadValue(st, PLL_RST_CYCLES, LOCK_TIMEOUT,
                                LOCK_STABLE_CYCLES, CORE_RST_HOLD));
   endfunction

   assign cntZero  = (cntQ == '0);
   assign retryInc = retryQ + 8'd1;

   // State register and registered outputs. Reset puts the sequencer at the
   // start of a PLL reset pulse with the CPU held in reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stateQ    <= PLL_RST;
         cntQ      <= RESET_CNT;
         pllRstQ   <= 1'b1;
         sysRstNQ  <= 1'b0;
         lockedQ   <= 1'b0;
         lockLostQ <= 1'b0;
         faultQ    <= 1'b0;
         retryQ    <= '0;
         lossQ     <= '0;
      end else begin
         stateQ    <= stateD;
         cntQ      <= cntD;
         pllRstQ   <= pllRstD;
         sysRstNQ  <= sysRstND;
         lockedQ   <= lockedD;
         lockLostQ <= lockLostD;
         faultQ    <= faultD;
         retryQ    <= retryD;
         lossQ     <= lossD;
      end
   end

   // Next-state logic. A lock seen on the last WAIT_LOCK cycle beats the
   // timeout, and a loss seen on the last HOLD cycle beats the RUN entry,
   // because the lock test is checked before the counter in both states.
   // Outputs are decoded from the next state so they move on the same edge
   // as the state itself.
   always_comb begin
      stateD    = stateQ;
      retryD    = retryQ;
      lossD     = lossQ;
      lossEvent = 1'b0;
      cntD      = cntQ;

      case (stateQ)
         PLL_RST: begin
            if (cntZero) stateD = WAIT_LOCK;
         end
         WAIT_LOCK: begin
            if (lockS) begin
               stateD = STABLE;
            end else if (cntZero) begin
               retryD = retryInc;
               stateD = (retryInc == RETRY_LIMIT) ? FAULT : PLL_RST;
            end
         end
         STABLE: begin
            if (!lockS)       stateD = WAIT_LOCK;
            else if (cntZero) stateD = HOLD;
         end
         HOLD: begin
            if (!lockS) begin
               lossEvent = 1'b1;
               stateD    = PLL_RST;
            end else if (cntZero) begin
               stateD = RUN;
            end
         end
         RUN: begin
            if (!lockS) begin
               lossEvent = 1'b1;
               stateD    = PLL_RST;
            end
         end
         FAULT: begin
            stateD = FAULT;
         end
         default: begin
            stateD = PLL_RST;
         end
      endcase

      if ((stateD == RUN) && (stateQ != RUN)) retryD = '0;
      if (lossEvent && (lossQ != 8'hFF))     lossD = lossQ + 8'd1;

      if (stateD != stateQ) cntD = reloadFor(stateD);
      else if (!cntZero)    cntD = cntQ - 1'b1;

      pllRstD   = (stateD == PLL_RST) || (stateD == FAULT);
      sysRstND  = (stateD == RUN);
      lockedD   = (stateD == RUN);
      lockLostD = lossEvent;
      faultD    = (stateD == FAULT);
   end

   assign pll_rst_o   = pllRstQ;
   assign sys_rst_n_o = sysRstNQ;
   assign locked_o    = lockedQ;
   assign lock_lost_o = lockLostQ;
   assign fault_o     = faultQ;
   assign retry_cnt_o = retryQ;
   assign loss_cnt_o  = lossQ;

endmodule

// File: tb/tb_pll_rst_seq.sv
// Scoreboard bench for pll_rst_seq. The stimulus side plans each lock
// attempt in absolute cycle numbers and queues the output events it implies
// (RUN entry, lock loss, retry, fault); a negedge monitor detects those
// events on the DUT pins and checks them against the queue in order.
module tb_pll_rst_seq;

   localparam int SYNC = 2;
   localparam int PRC  = 4;
   localparam int LT   = 20;
   localparam int LSC  = 8;
   localparam int CRH  = 4;
   localparam int MR   = 2;

   localparam int EV_RUN   = 0;
   localparam int EV_LOSS  = 1;
   localparam int EV_RETRY = 2;
   localparam int EV_FAULT = 3;

   typedef struct {
      int kind;
      int cycle;
      int retry;
      int loss;
   } expEvent_t;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       pll_lock_i = 1'b0;
   logic       pll_rst_o;
   logic       sys_rst_n_o;
   logic       locked_o;
   logic       lock_lost_o;
   logic       fault_o;
   logic [7:0] retry_cnt_o;
   logic [7:0] loss_cnt_o;

   int        cyc = 0;
   int        testCount = 0;
   int        failCount = 0;
   expEvent_t expQ[$];

   int modelW;
   int modelRun;
   int modelLoss;
   int modelRetry;

   logic prevPll = 1'b1;
   logic prevSys = 1'b0;
   logic prevFault = 1'b0;

   pll_rst_seq #(
      .SYNC_STAGES        (SYNC),
      .PLL_RST_CYCLES     (PRC),
      .LOCK_TIMEOUT       (LT),
      .LOCK_STABLE_CYCLES (LSC),
      .CORE_RST_HOLD      (CRH),
      .MAX_RETRY          (MR),
      .CNT_W              (16)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .pll_lock_i  (pll_lock_i),
      .pll_rst_o   (pll_rst_o),
      .sys_rst_n_o (sys_rst_n_o),
      .locked_o    (locked_o),
      .lock_lost_o (lock_lost_o),
      .fault_o     (fault_o),
      .retry_cnt_o (retry_cnt_o),
      .loss_cnt_o  (loss_cnt_o)
   );

   // 100 MHz bench clock; the cycle number advances on every rising edge.
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic checkOutput(input string name, input int actual, input int expected);
      testCount++;
      if (actual != expected) begin
         failCount++;
         $display("[TB] FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, actual, expected);
      end
   endtask

   task automatic applyStimulus(input logic rstN, input logic lock);
      rst_n      = rstN;
      pll_lock_i = lock;
   endtask

   task automatic waitCycle(input int c);
      while (cyc < c) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic pushExp(input int kind, input int cycle, input int retry, input int loss);
      expEvent_t e;
      e.kind  = kind;
      e.cycle = cycle;
      e.retry = retry;
      e.loss  = loss;
      expQ.push_back(e);
   endtask

   // Compare one observed event with the oldest queued expectation.
   task automatic scoreEvent(input int kind);
      expEvent_t e;
      if (expQ.size() == 0) begin
         checkOutput("unexpectedEvent", kind, -1);
         return;
      end
      e = expQ.pop_front();
      checkOutput("eventKind", kind, e.kind);
      checkOutput("eventCycle", cyc, e.cycle);
      checkOutput("retryCnt", int'(retry_cnt_o), e.retry);
      checkOutput("lossCnt", int'(loss_cnt_o), e.loss);
      if (kind == EV_RUN) begin
         checkOutput("lockedInRun", int'(locked_o), 1);
         checkOutput("pllRstInRun", int'(pll_rst_o), 0);
      end
      if (kind == EV_LOSS) begin
         checkOutput("lossSysRst", int'(sys_rst_n_o), 0);
         checkOutput("lossLocked", int'(locked_o), 0);
         checkOutput("lossPllRst", int'(pll_rst_o), 1);
      end
      if (kind == EV_FAULT) begin
         checkOutput("faultSysRst", int'(sys_rst_n_o), 0);
      end
   endtask

   // Monitor: classify what the outputs did on the last rising edge. A
   // second consecutive lock_lost_o sample shows up as an extra loss event
   // and therefore as a scoreboard failure.
   always @(negedge clk) begin
      if (!rst_n) begin
         prevPll   = pll_rst_o;
         prevSys   = sys_rst_n_o;
         prevFault = fault_o;
      end else begin
         if (lock_lost_o)                 scoreEvent(EV_LOSS);
         else if (fault_o && !prevFault)  scoreEvent(EV_FAULT);
         else if (pll_rst_o && !prevPll)  scoreEvent(EV_RETRY);
         if (sys_rst_n_o && !prevSys)     scoreEvent(EV_RUN);
         prevPll   = pll_rst_o;
         prevSys   = sys_rst_n_o;
         prevFault = fault_o;
      end
   end

   // Hold reset for three edges, check the reset values and release. The
   // first WAIT_LOCK edge is PLL_RST cycles after the release.
   task automatic doReset();
      applyStimulus(1'b0, 1'b0);
      waitCycle(cyc + 3);
      checkOutput("rstPllRst", int'(pll_rst_o), 1);
      checkOutput("rstSysRst", int'(sys_rst_n_o), 0);
      checkOutput("rstLocked", int'(locked_o), 0);
      checkOutput("rstLockLost", int'(lock_lost_o), 0);
      checkOutput("rstFault", int'(fault_o), 0);
      checkOutput("rstRetry", int'(retry_cnt_o), 0);
      checkOutput("rstLoss", int'(loss_cnt_o), 0);
      applyStimulus(1'b1, 1'b0);
      modelW     = cyc + PRC;
      modelLoss  = 0;
      modelRetry = 0;
   endtask

   task automatic lossAt(input int x);
      modelLoss = (modelLoss >= 255) ? 255 : modelLoss + 1;
      pushExp(EV_LOSS, x, modelRetry, modelLoss);
      modelW = x + PRC;
   endtask

   // One lock attempt starting from the WAIT_LOCK entry in modelW.
   //   failCnt   - timeouts to let pass before raising the lock
   //   dd        - cycles into WAIT_LOCK at which the lock pin rises
   //   glitchK   - STABLE cycle (1..LSC) at which a one-cycle dropout is seen, 0 none
   //   holdLossK - HOLD cycle (1..CRH) at which the lock is lost, 0 none,
   //               negative when the caller aborts the attempt itself
   // The synchronized lock is seen by the sequencer SYNC+1 edges after the
   // pin moves.
   task automatic attemptLock(input int failCnt, input int dd, input int glitchK,
                              input int holdLossK, output int holdEntry);
      int t;
      int s;
      int g;
      int x;
      for (int i = 0; i < failCnt; i++) begin
         modelRetry++;
         pushExp(EV_RETRY, modelW + LT, modelRetry, modelLoss);
         modelW = modelW + LT + PRC;
      end
      t = modelW + dd;
      waitCycle(t);
      applyStimulus(1'b1, 1'b1);
      s = t + SYNC + 1;
      if (glitchK > 0) begin
         g = s + glitchK - SYNC - 1;
         waitCycle(g);
         applyStimulus(1'b1, 1'b0);
         waitCycle(g + 1);
         applyStimulus(1'b1, 1'b1);
         s = s + glitchK + 1;
      end
      holdEntry = s + LSC;
      if (holdLossK > 0) begin
         x = holdEntry + holdLossK;
         waitCycle(x - SYNC - 1);
         applyStimulus(1'b1, 1'b0);
         lossAt(x);
      end else if (holdLossK == 0) begin
         modelRun   = holdEntry + CRH;
         modelRetry = 0;
         pushExp(EV_RUN, modelRun, 0, modelLoss);
      end
   endtask

   // Drop the lock while running; the loss is seen at least one edge into RUN.
   task automatic runLoss(input int m);
      int base;
      int x;
      base = (cyc > modelRun - SYNC - 1) ? cyc : modelRun - SYNC - 1;
      x    = base + m + SYNC + 1;
      waitCycle(x - SYNC - 1);
      applyStimulus(1'b1, 1'b0);
      lossAt(x);
   endtask

   task automatic drain(input int c);
      waitCycle(c);
      checkOutput("scoreboardEmpty", expQ.size(), 0);
   endtask

   initial begin
      int hAt;
      int fc;
      int fCnt;
      int dd;
      int gk;
      int hk;

      modelRun = 0;
      doReset();

      // Clean lock three cycles into the first WAIT_LOCK.
      attemptLock(0, 3, 0, 0, hAt);
      drain(modelRun + 2);

      // Lock seen on the final timeout cycle must win over the retry.
      runLoss(5);
      attemptLock(0, LT - SYNC - 1, 0, 0, hAt);
      drain(modelRun + 2);

      // One timeout, then a successful second attempt.
      runLoss(1);
      attemptLock(1, 6, 0, 0, hAt);
      drain(modelRun + 2);

      // Dropout after five stable cycles restarts the stable count.
      runLoss(2);
      attemptLock(0, 2, 6, 0, hAt);
      drain(modelRun + 2);

      // Loss on the last HOLD cycle beats the RUN entry.
      runLoss(3);
      attemptLock(0, 4, 0, CRH, hAt);
      attemptLock(0, 1, 0, 0, hAt);
      drain(modelRun + 2);

      // Randomized mixes of the above.
      for (int i = 0; i < 10; i++) begin
         fCnt = int'($urandom_range(0, 1));
         dd   = int'($urandom_range(0, LT - SYNC - 1));
         gk   = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, LSC)) : 0;
         hk   = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, CRH)) : 0;
         runLoss(int'($urandom_range(1, 10)));
         attemptLock(fCnt, dd, gk, hk, hAt);
         if (hk > 0) attemptLock(0, int'($urandom_range(0, LT - SYNC - 1)), 0, 0, hAt);
         drain(modelRun + 2);
      end

      // Asynchronous reset in the middle of HOLD.
      runLoss(2);
      attemptLock(0, 5, 0, -1, hAt);
      waitCycle(hAt + 2);
      checkOutput("holdBeforeReset", expQ.size(), 0);
      checkOutput("holdPllRst", int'(pll_rst_o), 0);
      #2;
      applyStimulus(1'b0, 1'b1);
      #1;
      checkOutput("asyncPllRst", int'(pll_rst_o), 1);
      checkOutput("asyncSysRst", int'(sys_rst_n_o), 0);
      checkOutput("asyncLocked", int'(locked_o), 0);
      checkOutput("asyncLoss", int'(loss_cnt_o), 0);
      checkOutput("asyncRetry", int'(retry_cnt_o), 0);
      doReset();

      // Never lock: retries run out and FAULT must persist until reset.
      fc = 0;
      for (int i = 0; i < MR; i++) begin
         modelRetry++;
         fc = modelW + LT;
         pushExp((modelRetry == MR) ? EV_FAULT : EV_RETRY, fc, modelRetry, modelLoss);
         modelW = modelW + LT + PRC;
      end
      drain(fc + 200);
      checkOutput("faultSticky", int'(fault_o), 1);
      checkOutput("faultPllRst", int'(pll_rst_o), 1);
      checkOutput("faultSysRst", int'(sys_rst_n_o), 0);
      checkOutput("faultLocked", int'(locked_o), 0);
      checkOutput("faultRetry", int'(retry_cnt_o), MR);
      doReset();

      // Normal operation resumes after the fault is cleared.
      attemptLock(0, 3, 0, 0, hAt);
      drain(modelRun + 2);

      $display("[TB] %0d tests run, %0d failed", testCount, failCount);
      $finish;
   end

endmodule

// File: doc/pll_rst_seq.md
Name: pll_rst_seq

Overview:
- Consumer side of the PLL wrapper. Drives the PLL reset input and watches its asynchronous lock output.
- Runs on the free-running 50 MHz board clock, never on a PLL output.
- Issues PLL resets, waits for a stable lock, then releases the CPU-domain reset.
- Retries a PLL that does not lock in time. On lock loss, re-asserts system reset and re-runs the sequence.

Parameters:
- SYNC_STAGES, 2, flops in the lock synchronizer (min 2)
- PLL_RST_CYCLES, 16, cycles pll_rst_o is held high per attempt (min 1)
- LOCK_TIMEOUT, 50000, cycles allowed in WAIT_LOCK before an attempt fails (1 ms at 50 MHz)
- LOCK_STABLE_CYCLES, 1024, consecutive locked cycles required before lock is trusted
- CORE_RST_HOLD, 64, extra cycles sys_rst_n_o stays low after a stable lock
- MAX_RETRY, 8, failed attempts before FAULT (1..255)
- CNT_W, 16, width of the shared down-counter; must hold the largest cycle parameter

Ports:
- clk  in  1  free-running board clock (50 MHz)
- rst_n  in  1  asynchronous, active-low reset
- pll_lock_i  in  1  PLL lock, asynchronous to clk
- pll_rst_o  out  1  PLL reset request, active high
- sys_rst_n_o  out  1  CPU-domain reset, active low, registered
- locked_o  out  1  high only in RUN
- lock_lost_o  out  1  one-cycle pulse on lock loss in HOLD or RUN
- fault_o  out  1  sticky; retries exhausted
- retry_cnt_o  out  8  failed attempts since last RUN entry
- loss_cnt_o  out  8  saturating count of lock-loss events since rst_n

Behaviour:
- Reset: clock is clk; reset is asynchronous, active-low (rst_n). Reset values:
  - state PLL_RST, counter = PLL_RST_CYCLES-1
  - pll_rst_o=1, sys_rst_n_o=0, locked_o=0, lock_lost_o=0, fault_o=0
  - retry_cnt_o=0, loss_cnt_o=0, synchronizer flops all 0
- lock_s: pll_lock_i after SYNC_STAGES flops. All decisions use lock_s only.
- Register timing: every output is a flop driven from the next-state logic, so outputs change on the same edge as the state.
- Counter: one down-counter, reloaded on every state entry.
- States and transitions:
  - PLL_RST: pll_rst_o=1. After exactly PLL_RST_CYCLES cycles, go to WAIT_LOCK.
  - WAIT_LOCK: pll_rst_o=0.
    - lock_s=1 -> STABLE.
    - Otherwise, after LOCK_TIMEOUT cycles, retry_cnt++.
    - If the new value equals MAX_RETRY -> FAULT, else -> PLL_RST.
  - STABLE:
    - lock_s=0 -> WAIT_LOCK with the timeout reloaded. retry_cnt is unchanged and no loss is counted.
    - After LOCK_STABLE_CYCLES consecutive lock_s=1 cycles -> HOLD.
  - HOLD: sys_rst_n_o stays 0.
    - After CORE_RST_HOLD cycles -> RUN.
    - lock_s=0 -> loss event, then PLL_RST.
  - RUN: sys_rst_n_o=1 and locked_o=1 from the first RUN cycle; retry_cnt cleared on entry.
    - lock_s=0 -> loss event, then PLL_RST. On that same edge sys_rst_n_o goes 0 and locked_o goes 0.
  - FAULT: pll_rst_o=1, sys_rst_n_o=0, fault_o=1. Terminal; only rst_n exits.
- Loss event: lock_lost_o=1 for exactly one cycle; loss_cnt++ saturating at 255.
- Simultaneous events:
  - In WAIT_LOCK, if lock_s=1 on the last timeout cycle, lock wins -> STABLE, no retry counted.
  - In HOLD, if lock_s=0 on the final cycle, the loss wins.
- Reset mid-operation: rst_n low in any state forces reset values immediately (asynchronously), including sys_rst_n_o=0.
- Latency from a clean lock:
  - pll_lock_i rises while in WAIT_LOCK.
  - sys_rst_n_o rises SYNC_STAGES + LOCK_STABLE_CYCLES + CORE_RST_HOLD + 1 cycles later (±1 cycle for async sampling).
- Glitch filtering: a lock glitch shorter than one clk is either filtered by the synchronizer or treated as a real loss. Never X-propagating.

Decomposition:
- Package pll_seq_pkg:
  - state encoding: PLL_RST, WAIT_LOCK, STABLE, HOLD, RUN, FAULT
  - default parameter constants
  - function returning the counter reload value per state
- Sub-module cdc_sync_bit: parameterized SYNC_STAGES flop chain with async active-low reset. Reusable across the codebase.

Test Plan:
All scenarios use SYNC_STAGES=2, PLL_RST_CYCLES=4, LOCK_TIMEOUT=20, LOCK_STABLE_CYCLES=8, CORE_RST_HOLD=4, MAX_RETRY=2.
- Clean lock: release rst_n; pll_rst_o high 4 cycles. Raise pll_lock_i 3 cycles into WAIT_LOCK -> sys_rst_n_o and locked_o rise 15 (±1) cycles later; retry_cnt_o=0.
- Timeout retry: hold pll_lock_i low -> pll_rst_o re-asserts after 20 WAIT_LOCK cycles, retry_cnt_o=1. Lock on the 2nd attempt -> RUN, retry_cnt_o returns to 0.
- Fault: never lock -> after the 2nd timeout fault_o=1, pll_rst_o=1, sys_rst_n_o=0. Stays so for 200 cycles; rst_n pulse clears it.
- Unstable lock: in STABLE, drop lock for 1 cycle after 5 locked cycles -> back to WAIT_LOCK, sys_rst_n_o stays 0, loss_cnt_o=0; the 8-cycle stable count restarts.
- Run-time loss: in RUN, drop pll_lock_i -> 2–3 cycles later lock_lost_o pulses once, sys_rst_n_o=0, locked_o=0, pll_rst_o=1, loss_cnt_o=1. Re-lock -> RUN again.
- Async reset mid-HOLD: assert rst_n between clock edges -> all outputs at reset values before the next edge.
